tile_renderer: RTL and testbench

Downstream stage of the game manager. Captures the eight 40-bit tile rows (8 × 5-bit image indices each) once per video frame and, for each incoming display pixel coordinate, produces the tile-image ROM address and flags for the VGA colour path. Lives between the game logic and the VGA controller / image ROM. Frame-synchronous capture keeps the picture tear-free while the game updates rows mid-frame.

---
 rtl/tile_renderer_pkg.sv | 67 ++++++
 rtl/tile_frame_latch.sv | 50 +++++
 rtl/tile_renderer.sv | 107 ++++++++++
 tb/tb_tile_renderer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tile_renderer_pkg.sv
// Shared constants, image-index names and pipeline payload types for tile_renderer.
package tile_renderer_pkg;

    localparam int unsigned IDX_W        = 5;
    localparam int unsigned TILE_PX      = 16;
    localparam int unsigned GRID_N       = 8;
    localparam int unsigned IDX_DARK     = 31;
    localparam int unsigned IDX_DARK_MIN = 19;

    localparam int unsigned SUB_W   = $clog2(TILE_PX);
    localparam int unsigned POS_W   = $clog2(GRID_N);
    localparam int unsigned ROW_W   = IDX_W * GRID_N;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned ADDR_W  = IDX_W + 2 * SUB_W;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [IDX_W-1:0] {
        NUM0     = 5'd0,
        NUM1     = 5'd1,
        NUM2     = 5'd2,
        NUM3     = 5'd3,
        NUM4     = 5'd4,
        NUM5     = 5'd5,
        NUM6     = 5'd6,
        NUM7     = 5'd7,
        NUM8     = 5'd8,
        NUM9     = 5'd9,
        PLAYER1  = 5'd10,
        PLAYER2  = 5'd11,
        PLAYER3  = 5'd12,
        BULLET1  = 5'd13,
        BULLET2  = 5'd14,
        BULLET3  = 5'd15,
        BUBBLE1  = 5'd16,
        BUBBLE2  = 5'd17,
        BUBBLE3  = 5'd18,
        IMG_DARK = 5'd31
    } img_idx_e;

    // One grid row; element GRID_N-1 (the top 5 bits) holds column 0.
    typedef logic [GRID_N-1:0][IDX_W-1:0] tile_row_t;

    // Stage-1 payload: decoded tile position and sub-pixel offsets.
    typedef struct packed {
        logic             valid;
        logic             in_region;
        logic             grid;
        logic [POS_W-1:0] row;
        logic [POS_W-1:0] col;
        logic [SUB_W-1:0] py;
        logic [SUB_W-1:0] px;
    } s1_t;

    // Stage-2 payload: what the colour path sees.
    typedef struct packed {
        logic              valid;
        logic              dark;
        logic              grid;
        logic [ADDR_W-1:0] addr;
    } pix_t;

    // Indices at or above IDX_DARK_MIN have no image and render black.
    function automatic logic idx_is_dark(input logic [IDX_W-1:0] idx);
        return idx >= IDX_W'(IDX_DARK_MIN);
    endfunction

endpackage

// File: rtl/tile_frame_latch.sv
// Per-frame snapshot of the eight tile rows plus a captured-frame counter.
module tile_frame_latch
    import tile_renderer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start_i,
    input  tile_row_t [GRID_N-1:0]   rows_i,
    input  logic [POS_W-1:0]         rd_row_i,
    input  logic [POS_W-1:0]         rd_col_i,
    output logic [IDX_W-1:0]         rd_idx_o_c,
    output logic [CNT_W-1:0]         frame_cnt_o
);

    localparam tile_row_t ROW_DARK = {GRID_N{IDX_W'(IDX_DARK)}};

    tile_row_t [GRID_N-1:0] rows_q, rows_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    tile_row_t              rd_row_sel;

    // Copy all rows and bump the frame count on frame_start.
    always_comb begin
        rows_d = rows_q;
        cnt_d  = cnt_q;
        if (frame_start_i) begin
            rows_d = rows_i;
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    // Snapshot registers; reset fills every cell with the dark index.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rows_q <= {GRID_N{ROW_DARK}};
            cnt_q  <= '0;
        end else begin
            rows_q <= rows_d;
            cnt_q  <= cnt_d;
        end
    end

    // Combinational read: column 0 lives in the most significant slot.
    always_comb begin
        rd_row_sel = rows_q[rd_row_i];
        rd_idx_o_c = rd_row_sel[POS_W'(GRID_N - 1) - rd_col_i];
    end

    assign frame_cnt_o = cnt_q;

endmodule

// File: rtl/tile_renderer.sv
// Maps display coordinates to tile-image ROM addresses, two-stage pipeline.
// Optional feature macro: GRID_LINE_EN (1-pixel tile border on out_grid).
module tile_renderer
    import tile_renderer_pkg::*;
#(
    parameter int unsigned X0       = 192,
    parameter int unsigned Y0       = 112,
    parameter int unsigned SCALE_SH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic [ROW_W-1:0]     Row1,
    input  logic [ROW_W-1:0]     Row2,
    input  logic [ROW_W-1:0]     Row3,
    input  logic [ROW_W-1:0]     Row4,
    input  logic [ROW_W-1:0]     Row5,
    input  logic [ROW_W-1:0]     Row6,
    input  logic [ROW_W-1:0]     Row7,
    input  logic [ROW_W-1:0]     Row8,
    input  logic                 in_valid,
    input  logic [COORD_W-1:0]   h_cnt,
    input  logic [COORD_W-1:0]   v_cnt,
    output logic                 out_valid,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 out_dark,
    output logic                 out_grid,
    output logic [CNT_W-1:0]     frame_cnt
);

    localparam int unsigned GRID_SPAN = (GRID_N * TILE_PX) << SCALE_SH;
    localparam int unsigned TILE_SH   = SUB_W + SCALE_SH;

    tile_row_t [GRID_N-1:0] rows;
    logic [COORD_W-1:0]     dx, dy;
    logic                   in_x, in_y;
    logic [IDX_W-1:0]       idx;
    logic                   dark;
    s1_t                    s1_q, s1_d;
    pix_t                   out_q, out_d;

    assign rows = {Row8, Row7, Row6, Row5, Row4, Row3, Row2, Row1};

    tile_frame_latch u_latch (
        .clk           (clk),
        .rst           (rst),
        .frame_start_i (frame_start),
        .rows_i        (rows),
        .rd_row_i      (s1_q.row),
        .rd_col_i      (s1_q.col),
        .rd_idx_o_c    (idx),
        .frame_cnt_o   (frame_cnt)
    );

    // Stage 1: grid-relative offsets, region test and tile/sub-pixel split.
    always_comb begin
        dx   = h_cnt - COORD_W'(X0);
        dy   = v_cnt - COORD_W'(Y0);
        in_x = (h_cnt >= COORD_W'(X0)) && (h_cnt < COORD_W'(X0 + GRID_SPAN));
        in_y = (v_cnt >= COORD_W'(Y0)) && (v_cnt < COORD_W'(Y0 + GRID_SPAN));

        s1_d           = '0;
        s1_d.valid     = in_valid;
        s1_d.in_region = in_x && in_y;
        s1_d.col       = POS_W'(dx >> TILE_SH);
        s1_d.row       = POS_W'(dy >> TILE_SH);
        s1_d.px        = SUB_W'(dx >> SCALE_SH);
        s1_d.py        = SUB_W'(dy >> SCALE_SH);
`ifdef GRID_LINE_EN
        // Border pixel: first display pixel of a tile in either axis.
        s1_d.grid      = in_x && in_y &&
                         ((COORD_W'(dx << (COORD_W - TILE_SH)) == '0) ||
                          (COORD_W'(dy << (COORD_W - TILE_SH)) == '0));
`else
        s1_d.grid      = 1'b0;
`endif
    end

    // Stage 2: look up the captured index and form the ROM address.
    always_comb begin
        dark  = !s1_q.in_region || idx_is_dark(idx);
        out_d = '0;
        if (s1_q.valid) begin
            out_d.valid = 1'b1;
            out_d.dark  = dark;
            out_d.grid  = s1_q.grid;
            out_d.addr  = dark ? '0 : {idx, s1_q.py, s1_q.px};
        end
    end

    // Pipeline registers; reset flushes both stages.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q  <= '0;
            out_q <= '0;
        end else begin
            s1_q  <= s1_d;
            out_q <= out_d;
        end
    end

    assign out_valid = out_q.valid;
    assign out_addr  = out_q.addr;
    assign out_dark  = out_q.dark;
    assign out_grid  = out_q.grid;

endmodule

// File: tb/tb_tile_renderer.sv
// Scoreboard bench for tile_renderer (X0=192, Y0=112, SCALE_SH=1, 32-pixel tiles).
module tb_tile_renderer;
    import tile_renderer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [39:0] row_in [8];
    logic        in_valid;
    logic [9:0]  h_cnt, v_cnt;
    logic        out_valid;
    logic [12:0] out_addr;
    logic        out_dark;
    logic        out_grid;
    logic [7:0]  frame_cnt;

    typedef struct {
        logic        dark;
        logic [12:0] addr;
        logic        grid;
        int          id;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [4:0]  tiles [8][8];

    tile_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .Row1        (row_in[0]),
        .Row2        (row_in[1]),
        .Row3        (row_in[2]),
        .Row4        (row_in[3]),
        .Row5        (row_in[4]),
        .Row6        (row_in[5]),
        .Row7        (row_in[6]),
        .Row8        (row_in[7]),
        .in_valid    (in_valid),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .out_valid   (out_valid),
        .out_addr    (out_addr),
        .out_dark    (out_dark),
        .out_grid    (out_grid),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic gexp(input logic g);
`ifdef GRID_LINE_EN
        return g;
`else
        return 1'b0 & g;
`endif
    endfunction

    task automatic build_rows();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                row_in[r][39-5*c -: 5] = tiles[r][c];
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    // Drive one pixel for one cycle and queue its hand-computed result.
    task automatic px(input int h, input int v, input logic d, input logic [12:0] a,
                      input logic g, input int id, input logic fs);
        exp_t x;
        x.dark = d; x.addr = a; x.grid = gexp(g); x.id = id;
        sb.push_back(x);
        in_valid = 1'b1; h_cnt = 10'(h); v_cnt = 10'(v); frame_start = fs;
        @(posedge clk); #1;
        in_valid = 1'b0; frame_start = 1'b0;
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    // Monitor: compare every presented output against the queue head.
    always @(negedge clk) begin
        if (out_valid) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out got addr=%h dark=%b", out_addr, out_dark);
            end else begin
                e = sb.pop_front();
                if (out_dark !== e.dark || out_addr !== e.addr || out_grid !== e.grid) begin
                    n_fail++;
                    $display("FAIL pix%0d got dark=%b addr=%h grid=%b expected dark=%b addr=%h grid=%b",
                             e.id, out_dark, out_addr, out_grid, e.dark, e.addr, e.grid);
                end
            end
        end else if (out_dark !== 1'b0 || out_addr !== 13'h0 || out_grid !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_zero got dark=%b addr=%h grid=%b expected all 0",
                     out_dark, out_addr, out_grid);
        end
    end

    initial begin
        rst = 1'b0; frame_start = 1'b0; in_valid = 1'b0; h_cnt = '0; v_cnt = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                tiles[r][c] = 5'd31;
        build_rows();

        // Reset for three cycles.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_frame_cnt", int'(frame_cnt), 0);
        rst = 1'b1;

        // Rows presented without frame_start must stay invisible.
        tiles[1][3] = 5'd17;
        tiles[0][0] = 5'd5;
        tiles[0][7] = 5'd18;
        tiles[0][1] = 5'd19;
        tiles[0][2] = 5'd31;
        tiles[7][4] = 5'd10;
        build_rows();
        px(192, 112, 1, 13'h0, 1, 1, 0);
        px(300, 200, 1, 13'h0, 0, 2, 0);
        px(447, 367, 1, 13'h0, 0, 3, 0);
        px(100,  50, 1, 13'h0, 0, 4, 0);
        px(293, 153, 1, 13'h0, 0, 5, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_frame_cnt", int'(frame_cnt), 0);

        // First capture, then address generation.
        pulse();
        chk("frame_cnt_1", int'(frame_cnt), 1);
        px(293, 153, 0, 13'h1142, 0, 10, 0);

        // Horizontal and vertical grid edges.
        px(191, 112, 1, 13'h0,   0, 11, 0);
        px(192, 112, 0, 13'h500, 1, 12, 0);
        px(447, 112, 0, 13'h120F, 1, 13, 0);
        px(448, 112, 1, 13'h0,   0, 14, 0);
        px(192, 111, 1, 13'h0,   0, 15, 0);
        px(192, 367, 1, 13'h0,   1, 16, 0);
        px(192, 368, 1, 13'h0,   0, 17, 0);

        // Dark indices 19 and 31; grid line at dx=32 but not dx=33.
        px(224, 132, 1, 13'h0, 1, 20, 0);
        px(266, 132, 1, 13'h0, 0, 21, 0);
        px(224, 152, 1, 13'h0, 1, 22, 0);
        px(225, 152, 1, 13'h0, 0, 23, 0);

        // Tear-free update of Row8 column 4.
        px(326, 338, 0, 13'h0A13, 0, 30, 0);
        tiles[7][4] = 5'd12;
        build_rows();
        px(326, 338, 0, 13'h0A13, 0, 31, 0);
        pulse();
        px(326, 338, 0, 13'h0C13, 0, 32, 0);
        tiles[7][4] = 5'd16;
        build_rows();
        px(326, 338, 0, 13'h0C13, 0, 33, 0);
        px(326, 338, 0, 13'h1013, 0, 34, 1);
        chk("frame_cnt_3", int'(frame_cnt), 3);

        // Counter wrap.
        repeat (252) pulse();
        chk("frame_cnt_255", int'(frame_cnt), 255);
        pulse();
        chk("frame_cnt_wrap", int'(frame_cnt), 0);
        pulse();
        chk("frame_cnt_after_wrap", int'(frame_cnt), 1);

        // Mid-stream reset with a coincident frame_start: pixel dropped, latch dark.
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b1; h_cnt = 10'd192; v_cnt = 10'd112;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b0; frame_start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; frame_start = 1'b0;
        chk("midreset_valid", int'(out_valid), 0);
        chk("midreset_frame_cnt", int'(frame_cnt), 0);
        px(192, 112, 1, 13'h0, 1, 40, 0);
        px(293, 153, 1, 13'h0, 0, 41, 0);

        // Drain with a bounded wait.
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
